// File: rtl/bf_output_tx.sv
`default_nettype none
// ============================================================================
// Module   : bf_output_tx
// Purpose  : Output-side responder for the brainfuck CPU '.' instruction.
//            Accepts bytes from the CPU into a small FIFO, acknowledges each
//            accepted byte with a one-cycle step_req pulse, and serialises
//            the queued bytes as back-to-back 8N1 UART frames on tx.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   system clock
//   resetn     in   asynchronous active-low reset
//   flush      in   synchronous clear of FIFO and transmitter
//   out_valid  in   CPU presents out_byte (held until accepted)
//   out_byte   in   [7:0] byte to transmit
//   out_ready  out  FIFO not full (from registered count)
//   step_req   out  registered pulse, cycle after an accept
//   tx         out  UART serial line, idle high, registered
//   tx_busy    out  frame in progress or FIFO non-empty
//   fifo_count out  [$clog2(FIFO_DEPTH):0] FIFO occupancy
// ============================================================================
module bf_output_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          flush,
    input  logic                          out_valid,
    input  logic [7:0]                    out_byte,
    output logic                          out_ready,
    output logic                          step_req,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state_q;
    logic [BW-1:0]   baud_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            tx_q;
    logic            step_req_q;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;

    logic            push;
    logic            pop;
    logic            baud_last;
    logic            fifo_nonempty;
    logic [7:0]      head;

    assign baud_last     = (baud_q == BAUD_LAST);
    assign fifo_nonempty = (count_q != '0);
    assign head          = mem_q[rd_ptr_q];

    // Readiness comes from the registered count only, so a same-cycle pop
    // can never open a slot for a push while full.
    assign out_ready = (count_q != COUNT_FULL);

    // flush dominates: no write and no acknowledge in a flush cycle.
    assign push = out_valid && out_ready && !flush;

    // Pop happens when idle, or on the last stop-bit cycle to chain the next
    // frame with no idle gap.
    assign pop = !flush && fifo_nonempty &&
                 ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_last));

    assign count_d = count_q + CW'(push) - CW'(pop);

    // FIFO storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= out_byte;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            step_req_q <= 1'b0;
        end else if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            step_req_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            step_req_q <= push;
        end
    end

    // Transmit FSM; tx_q holds the line level for the coming cycle so the
    // pin is driven straight from a flop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else if (flush) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        shift_q <= head;
                        baud_q  <= '0;
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= S_DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q <= head;
                            tx_q    <= 1'b0;
                            state_q <= S_START;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx         = tx_q;
    assign step_req   = step_req_q;
    assign fifo_count = count_q;
    assign tx_busy    = (state_q != S_IDLE) || fifo_nonempty;

endmodule
`default_nettype wire

// File: tb/tb_bf_output_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_bf_output_tx
// Purpose  : Self-checking bench for bf_output_tx. A frame-level reference
//            model (byte queue plus "cycles left in current frame") predicts
//            every output each cycle; directed scenarios add explicit checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bf_output_tx;

    localparam int C_CPB   = 4;
    localparam int C_DEPTH = 4;
    localparam int C_FRAME = 10 * C_CPB;

    logic       clk = 1'b0;
    logic       resetn;
    logic       flush;
    logic       out_valid;
    logic [7:0] out_byte;
    logic       out_ready;
    logic       step_req;
    logic       tx;
    logic       tx_busy;
    logic [2:0] fifo_count;

    bf_output_tx #(
        .CLKS_PER_BIT (C_CPB),
        .FIFO_DEPTH   (C_DEPTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_byte   (out_byte),
        .out_ready  (out_ready),
        .step_req   (step_req),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] m_q[$];     // bytes waiting in the FIFO
    logic [7:0] m_cur;      // byte of the frame on the line
    int         m_fl = 0;   // frame cycles remaining, including current one
    bit         m_step = 0;

    int obs_steps = 0;
    int obs_peak  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_tx();
        int pos, b;
        if (m_fl == 0) return 1'b1;
        pos = C_FRAME - m_fl;
        b   = pos / C_CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_cur[b-1];
    endfunction

    function automatic int cur_bit_slot();
        return (m_fl == 0) ? -1 : (C_FRAME - m_fl) / C_CPB;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_fl   = 0;
        m_step = 0;
    endtask

    task automatic check_outputs();
        chk("tx",         tx,         exp_tx());
        chk("step_req",   step_req,   m_step);
        chk("fifo_count", fifo_count, m_q.size());
        chk("out_ready",  out_ready,  m_q.size() < C_DEPTH);
        chk("tx_busy",    tx_busy,    (m_fl > 0) || (m_q.size() > 0));
    endtask

    // One clock: advance the model with pre-edge inputs, then compare.
    task automatic tick();
        bit acc, pp;
        @(posedge clk);
        if (!resetn || flush) begin
            model_reset();
        end else begin
            acc = out_valid && (m_q.size() < C_DEPTH);
            pp  = (m_q.size() > 0) && (m_fl <= 1);
            m_step = acc;
            if (pp) begin
                m_cur = m_q.pop_front();
                m_fl  = C_FRAME;
            end else if (m_fl > 0) begin
                m_fl--;
            end
            if (acc) m_q.push_back(out_byte);
        end
        #1;
        check_outputs();
        if (step_req) obs_steps++;
        if (int'(fifo_count) > obs_peak) obs_peak = int'(fifo_count);
    endtask

    task automatic push_byte(input logic [7:0] b);
        int  n = 0;
        bit  acc;
        out_valid = 1'b1;
        out_byte  = b;
        do begin
            acc = (m_q.size() < C_DEPTH) && !flush && resetn;
            tick();
            n++;
        end while (!acc && n < 2000);
        if (!acc) chk("push_timeout", 32'd0, 32'd1);
        out_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_fl > 0 || m_q.size() > 0) && n < 2000) begin
            tick();
            n++;
        end
        chk("drain_timeout", (n < 2000), 1'b1);
        tick();
    endtask

    initial begin
        logic [9:0] frame41;
        int         n;

        resetn    = 1'b1;
        flush     = 1'b0;
        out_valid = 1'b0;
        out_byte  = 8'h00;

        // Reset state, asserted off the clock edge
        #2 resetn = 1'b0;
        #1;
        model_reset();
        chk("rst_tx",        tx,         1'b1);
        chk("rst_count",     fifo_count, 3'd0);
        chk("rst_out_ready", out_ready,  1'b1);
        chk("rst_step",      step_req,   1'b0);
        chk("rst_busy",      tx_busy,    1'b0);
        tick();
        tick();
        #3 resetn = 1'b1;
        tick();

        // Single byte 0x41: start, LSB-first data, stop, 4 cycles each
        frame41 = {1'b1, 8'h41, 1'b0};
        push_byte(8'h41);
        chk("s1_step", step_req, 1'b1);
        for (int k = 1; k <= C_FRAME; k++) begin
            tick();
            if (((k - 1) % C_CPB) == 2)
                chk("s1_bit", tx, frame41[(k - 1) / C_CPB]);
        end
        tick();
        chk("s1_busy_end", tx_busy, 1'b0);

        // Four consecutive pushes: peak occupancy 3, four acknowledges
        obs_steps = 0;
        obs_peak  = 0;
        push_byte(8'h55);
        push_byte(8'hAA);
        push_byte(8'h00);
        push_byte(8'hFF);
        wait_idle();
        chk("s2_steps", obs_steps, 4);
        chk("s2_peak",  obs_peak,  3);

        // Back-pressure: seven bytes held behind a full FIFO
        obs_steps = 0;
        push_byte(8'h11);
        for (int i = 0; i < 6; i++) push_byte(8'h20 + 8'(i));
        chk("s3_full_seen", obs_peak >= C_DEPTH, 1'b1);
        wait_idle();
        chk("s3_steps", obs_steps, 7);

        // Simultaneous pop and push at occupancy 2
        push_byte(8'hA1);
        push_byte(8'hB2);
        push_byte(8'hC3);
        n = 0;
        while (m_fl != 1 && n < 200) begin tick(); n++; end
        chk("s4_count_before", fifo_count, 3'd2);
        push_byte(8'hD4);
        chk("s4_pp_count", fifo_count, 3'd2);
        wait_idle();

        // Flush during data bit 3 of 0x3C, with a byte presented alongside
        push_byte(8'h3C);
        push_byte(8'h01);
        push_byte(8'h02);
        n = 0;
        while (cur_bit_slot() != 4 && n < 200) begin tick(); n++; end
        flush     = 1'b1;
        out_valid = 1'b1;
        out_byte  = 8'h99;
        tick();
        flush     = 1'b0;
        out_valid = 1'b0;
        chk("s5_tx",    tx,         1'b1);
        chk("s5_count", fifo_count, 3'd0);
        chk("s5_busy",  tx_busy,    1'b0);
        chk("s5_step",  step_req,   1'b0);
        push_byte(8'h5A);
        wait_idle();

        // Asynchronous reset in the middle of a start bit
        push_byte(8'hE7);
        tick();
        #2 resetn = 1'b0;
        #1;
        model_reset();
        chk("s6_tx_async",    tx,         1'b1);
        chk("s6_ready_async", out_ready,  1'b1);
        chk("s6_count_async", fifo_count, 3'd0);
        tick();
        #3 resetn = 1'b1;
        tick();
        push_byte(8'h7E);
        wait_idle();

        // Randomised traffic with occasional flushes
        for (int c = 0; c < 4000; c++) begin
            if (!out_valid && ($urandom_range(0, 99) < 40)) begin
                out_valid = 1'b1;
                out_byte  = 8'($urandom);
            end
            flush = ($urandom_range(0, 999) < 3);
            begin
                bit acc;
                acc = out_valid && (m_q.size() < C_DEPTH) && !flush;
                tick();
                if (acc) out_valid = 1'b0;
            end
        end
        flush     = 1'b0;
        out_valid = 1'b0;
        wait_idle();
        chk("end_busy", tx_busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bf_output_tx.md
Name: bf_output_tx

Overview:
- Output-side consumer for the brainfuck CPU's `.` instruction.
- Accepts bytes the CPU emits, buffers them in a small FIFO, and serialises them as 8N1 UART frames on a single `tx` pin.
- Returns the per-byte `step_req` acknowledge that releases the CPU from its step-wait after a `.`.
- Sits beside the CPU core at top level; the CPU is the producer, this block is the responder.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200); legal range 2 or more.
- FIFO_DEPTH, 16, byte FIFO entries; power of two, 2 or more.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear: empties the FIFO and aborts any frame; pulsed by top level on program start
- out_valid  input  1  CPU presents a byte; held until accepted
- out_byte  input  8  byte to transmit (the CPU's `.` value)
- out_ready  output  1  FIFO can accept; equals !full, combinational from the count register
- step_req  output  1  one-cycle pulse, registered, on the cycle after a byte is accepted
- tx  output  1  UART serial line, idle high
- tx_busy  output  1  high while a frame is in progress or the FIFO is non-empty
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, resetn low):
  - tx=1, step_req=0, tx_busy=0, fifo_count=0, out_ready=1.
  - FSM=IDLE; read/write pointers and baud/bit counters = 0.
  - tx goes high immediately, even mid-frame.
- Accept: a byte is accepted on a rising edge where out_valid && out_ready. That edge writes the FIFO and sets step_req=1 for exactly the next cycle.
- Full FIFO: when out_valid is high while full, nothing is written and there is no step_req; the byte is not lost because the producer holds it.
- Simultaneous push and pop: both occur; fifo_count is unchanged. A push while full is never permitted, even if a pop occurs that same cycle, because out_ready is derived from the registered count.
- Pointers: wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
- FSM states and transitions:
  - IDLE: tx=1. If fifo_count != 0: pop the head into the shift register, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] (LSB first) for CLKS_PER_BIT cycles per bit, shifting right after each bit. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle, if fifo_count != 0, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1. The bit boundary is at count==CLKS_PER_BIT-1; the counter resets to 0 on every state change.
- Latency:
  - An accept at edge N makes the FIFO non-empty at N+1; IDLE pops at edge N+1; tx falls after edge N+1.
  - First start bit therefore begins 1 cycle after the accept edge.
  - A frame is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames have no gap between the stop bit and the next start bit.
- tx is registered (driven from an FSM-registered value); it never glitches.
- tx_busy = (state != IDLE) || (fifo_count != 0).
- flush:
  - Next edge: FSM→IDLE, tx=1, FIFO empty, step_req=0.
  - If out_valid is high in the same cycle as flush, flush wins: no write, no step_req.
  - A truncated frame is acceptable; the line simply returns to idle high.
- Counter widths: the baud counter is sized $clog2(CLKS_PER_BIT); there must be no overflow at CLKS_PER_BIT=2.

Test Plan (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset, then push 0x41 → step_req pulses 1 cycle; tx=0 for 4 cycles; tx sequence 1,0,0,0,0,0,1,0 at 4 cycles each; tx=1 for 4 cycles; frame totals 40 cycles, then tx_busy=0.
- Push 0x55, 0xAA, 0x00, 0xFF on consecutive cycles → fifo_count peaks at 3 (the first byte pops on the next cycle); 4 step_req pulses; 4 contiguous frames (160 cycles) with no idle gap; decoded bytes match in order.
- Hold out_valid with 6 bytes while a frame is active → out_ready drops when fifo_count=4; step_req is absent while full; all 6 bytes eventually transmit in order with no loss or duplication.
- Pop and push on the same cycle when fifo_count=2 → fifo_count stays 2; the byte order is preserved.
- Assert flush during DATA bit 3 of 0x3C with 2 bytes queued → next cycle tx=1, fifo_count=0, tx_busy=0; the next push transmits correctly.
- Drop resetn asynchronously mid start bit → tx goes high without waiting for a clock edge and out_ready=1; after release, a push of 0x7E transmits a correct frame.
